// File: rtl/instr_prefetch_queue.sv
// Fetch stage ahead of CCG1: owns the fetch PC and buffers {instr, pc} pairs in a small FIFO.
// Halt-opcode detection is compiled in only when PREFETCH_HALT_EN is defined.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned IW      = 16,
  parameter logic [7:0]  HALT_OP = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [AW-1:0]                flush_pc,
  output logic [AW-1:0]                pm_addr,
  input  logic [IW-1:0]                pm_data,
  output logic                         issue_valid,
  output logic [IW-1:0]                issue_instr,
  output logic [AW-1:0]                issue_pc,
  input  logic                         issue_ready,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
`ifdef PREFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic [AW-1:0]   fetch_pc_r;
  logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [IW-1:0]   instr_mem_r [DEPTH];
  logic [AW-1:0]   pc_mem_r    [DEPTH];
  logic            valid_s, pop_s, push_s, halt_hit_s;

  assign valid_s    = (count_r != {CW{1'b0}});
  assign pop_s      = valid_s && issue_ready;
  assign push_s     = (state_r == RUN) && !flush && ((count_r < CW'(DEPTH)) || pop_s);
  // Without the macro HALT_EN is 0, so the FSM can never leave RUN.
  assign halt_hit_s = HALT_EN && push_s && (pm_data[IW-1:IW-8] == HALT_OP);

  assign pm_addr     = fetch_pc_r;
  assign issue_valid = valid_s;
  assign issue_instr = valid_s ? instr_mem_r[rd_ptr_r] : {IW{1'b0}};
  assign issue_pc    = valid_s ? pc_mem_r[rd_ptr_r]    : {AW{1'b0}};
  assign q_count     = count_r;

  // State register for the RUN/HALT fetch controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: flush always returns to RUN, a queued halt word stops fetch.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (flush) begin
          state_nxt_s = RUN;
        end else if (halt_hit_s) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        if (flush) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Fetch PC, FIFO pointers and occupancy; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= {AW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else if (flush) begin
      fetch_pc_r <= flush_pc;
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fetch_pc_r <= fetch_pc_r + AW'(1);
        wr_ptr_r   <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written at the write pointer on every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= {IW{1'b0}};
        pc_mem_r[i]    <= {AW{1'b0}};
      end
    end else if (push_s) begin
      instr_mem_r[wr_ptr_r] <= pm_data;
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: queue-based reference model, directed scenarios and random traffic.
// Honours PREFETCH_HALT_EN in its reference model.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;
`ifdef PREFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  flush_pc = 8'h00;
  logic [7:0]  pm_addr;
  logic [15:0] pm_data;
  logic        issue_valid;
  logic [15:0] issue_instr;
  logic [7:0]  issue_pc;
  logic        issue_ready = 1'b0;
  logic [2:0]  q_count;
  logic        halt_word_en = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference state: expected FIFO contents as {pc, instr}, fetch PC and halt flag.
  logic [23:0] sb[$];
  logic [7:0]  m_pc = 8'h00;
  bit          m_halt = 1'b0;

  function automatic logic [15:0] mem_word(input logic [7:0] a, input logic hw);
    if (hw && a == 8'h05) return 16'hFF00;
    return {a, ~a};
  endfunction

  assign pm_data = mem_word(pm_addr, halt_word_en);

  instr_prefetch_queue #(.DEPTH(4), .AW(8), .IW(16), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .pm_addr(pm_addr), .pm_data(pm_data),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
    .issue_ready(issue_ready), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the effect of one rising edge to the model (the monitor has already removed a popped head).
  task automatic model_edge();
    logic [15:0] w;
    if (!rst_n) return;
    if (flush) begin
      sb.delete();
      m_pc   = flush_pc;
      m_halt = 1'b0;
    end else if (!m_halt && sb.size() < DEPTH) begin
      w = mem_word(m_pc, halt_word_en);
      sb.push_back({m_pc, w});
      if (HALT_EN && w[15:8] == 8'hFF) m_halt = 1'b1;
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic step(input logic rdy, input logic fl, input logic [7:0] fpc);
    issue_ready = rdy;
    flush       = fl;
    flush_pc    = fpc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares the presented head against the scoreboard and retires it on a handshake.
  always @(negedge clk) begin
    logic [23:0] e;
    chk("valid", {31'd0, issue_valid}, {31'd0, sb.size() != 0});
    chk("q_count", {29'd0, q_count}, sb.size());
    chk("pm_addr", {24'd0, pm_addr}, {24'd0, m_pc});
    if (issue_valid && sb.size() != 0) begin
      e = sb[0];
      chk("head_pc", {24'd0, issue_pc}, {24'd0, e[23:16]});
      chk("head_instr", {16'd0, issue_instr}, {16'd0, e[15:0]});
      if (issue_ready) void'(sb.pop_front());
    end
  end

  initial begin
    logic [7:0] p;
    // Reset state
    #3;
    chk("rst_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_count", {29'd0, q_count}, 32'd0);
    chk("rst_pm_addr", {24'd0, pm_addr}, 32'd0);
    chk("rst_issue_pc", {24'd0, issue_pc}, 32'd0);
    chk("rst_issue_instr", {16'd0, issue_instr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1 stream
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00);
      p = 8'(i);
      chk("t1_pc", {24'd0, issue_pc}, {24'd0, p});
      chk("t1_instr", {16'd0, issue_instr}, {16'd0, p, ~p});
    end

    // T2 backpressure
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00);
    chk("t2_full", {29'd0, q_count}, 32'd4);
    chk("t2_pm_hold", {24'd0, pm_addr}, 32'h04);
    chk("t2_head", {24'd0, issue_pc}, 32'h00);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("t2_order", {24'd0, issue_pc}, i);
    end

    // T3 flush with three queued entries and a concurrent pop
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    chk("t3_count", {29'd0, q_count}, 32'd3);
    step(1'b1, 1'b1, 8'h40);
    chk("t3_empty", {31'd0, issue_valid}, 32'd0);
    chk("t3_count0", {29'd0, q_count}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("t3_pc40", {24'd0, issue_pc}, 32'h40);
    step(1'b1, 1'b0, 8'h00);
    chk("t3_pc41", {24'd0, issue_pc}, 32'h41);

    // T4 PC wrap
    step(1'b1, 1'b1, 8'hFE);
    step(1'b1, 1'b0, 8'h00);
    chk("t4_fe", {24'd0, issue_pc}, 32'hFE);
    step(1'b1, 1'b0, 8'h00);
    chk("t4_ff", {24'd0, issue_pc}, 32'hFF);
    chk("t4_wrap", {24'd0, pm_addr}, 32'h00);

    // T5 asynchronous reset between edges with two entries queued
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("t5_count2", {29'd0, q_count}, 32'd2);
    #1;
    rst_n = 1'b0;
    sb.delete();
    m_pc   = 8'h00;
    m_halt = 1'b0;
    #1;
    chk("t5_valid", {31'd0, issue_valid}, 32'd0);
    chk("t5_count", {29'd0, q_count}, 32'd0);
    issue_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    chk("t5_restart", {24'd0, issue_pc}, 32'h00);

    // T6 halt word at 05
    halt_word_en = 1'b1;
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00);
    if (HALT_EN) begin
      chk("t6_frozen", {24'd0, pm_addr}, 32'h06);
      chk("t6_drained", {31'd0, issue_valid}, 32'd0);
    end else begin
      chk("t6_runon", {24'd0, pm_addr}, 32'h0A);
      chk("t6_runon_pc", {24'd0, issue_pc}, 32'h09);
    end
    step(1'b1, 1'b1, 8'h10);
    step(1'b1, 1'b0, 8'h00);
    chk("t6_resume", {24'd0, issue_pc}, 32'h10);
    halt_word_en = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
